stage_if: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the decode stage and drives its instr, pc_id and nop_if inputs.
- Holds the PC and a word-addressed instruction memory, and produces the IF/ID pipeline register.
- Honours stall, redirects on taken jump/branch (isJumped) and stops fetching on a HALT word.
- Provides a program-load port so the debug unit can write the memory before execution.

---
 rtl/stage_if.sv | 80 ++++++++
 1 files changed

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, word-addressed instruction memory with a
// program-load port, and the IF/ID pipeline register feeding decode.
module stage_if #(
    parameter int          MEM_DEPTH = 256,
    parameter int          ADDR_W    = $clog2(MEM_DEPTH),
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              isJumped,
    input  logic [31:0]       jumpAddr,
    input  logic              load_mode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic [31:0]       instr,
    output logic [31:0]       pc_id,
    output logic              nop_if,
    output logic [31:0]       pc,
    output logic              halted
);

    logic [31:0]       mem [MEM_DEPTH];
    logic [ADDR_W-1:0] fetch_index;
    logic [31:0]       fetch_word;
    logic [31:0]       pc_next_seq;

    // Upper PC bits are dropped, so fetch addresses wrap modulo MEM_DEPTH*4.
    assign fetch_index = pc[ADDR_W+1:2];
    assign fetch_word  = mem[fetch_index];
    assign pc_next_seq = pc + 32'd4;

    // NOTE: the memory array has no reset so it maps onto plain RAM; a reset
    // loop over every word would force it into flops. Writes are blocked while
    // reset is asserted because reset outranks every other action.
    always_ff @(posedge clock) begin
        if (!reset && load_mode && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // NOTE: every register here uses non-blocking assignment so that all of
    // them sample the pre-edge values of pc, halted and the fetched word.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc     <= '0;
            instr  <= '0;
            pc_id  <= '0;
            nop_if <= 1'b1;
            halted <= 1'b0;
        end else if (load_mode) begin
            nop_if <= 1'b1;
        end else if (isJumped) begin
            // A redirect also cancels a HALT that was fetched down the wrong path.
            pc     <= {jumpAddr[31:2], 2'b00};
            instr  <= '0;
            pc_id  <= '0;
            nop_if <= 1'b1;
            halted <= 1'b0;
        end else if (halted) begin
            instr  <= '0;
            pc_id  <= '0;
            nop_if <= 1'b1;
        end else if (!stall) begin
            if (fetch_word == HALT_WORD) begin
                instr  <= '0;
                pc_id  <= '0;
                nop_if <= 1'b1;
                halted <= 1'b1;
            end else begin
                instr  <= fetch_word;
                pc_id  <= pc_next_seq;
                nop_if <= 1'b0;
                pc     <= pc_next_seq;
            end
        end
    end

endmodule
